mips_data_memory: RTL and testbench
===================================

Name: mips_data_memory

Overview:
Word-organised data memory that responds to the MIPS core's data port. It services single-word load and store requests, with a programmable number of wait states. It returns read data with a one-cycle acknowledge and flags misaligned or out-of-range accesses. It sits beside the core and acts as the responder for the core's data_addr / data_out / data_rd_wr / data_in signals.

Parameters:
base_addr, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
depth_words, 1024, number of 32-bit words; power of two, at least 2
wait_states, 1, extra cycles between accept and response; range 0..15

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  access request from the core; sampled only when ready=1
data_rd_wr  in  1  1 = read (load), 0 = write (store)
data_addr  in  32  byte address
data_out  in  32  write data from the core
data_in  out  32  read data to the core
ready  out  1  high only in IDLE; the block can accept a request
ack  out  1  one-cycle pulse marking request completion
err  out  1  valid with ack; 1 = misaligned or out-of-range access

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=1, ack=0, err=0, data_in=0, wait counter=0.
  - Memory array contents are not reset.
  - A request pending when reset asserts is dropped. A write not yet committed is never committed.
- Accept: on a rising edge with state=IDLE and req=1, latch data_addr, data_rd_wr and data_out. req in any other state is ignored.
- Access check on latched address, with offset = addr - base_addr (32-bit unsigned, wraps):
  - misaligned: addr[1:0] != 0
  - out-of-range: offset >= depth_words*4
  - index = offset[clog2(depth_words)+1:2]
- FSM states:
  - IDLE: ready=1. On accept, go to WAIT if wait_states>0, otherwise go to RESP.
  - WAIT: counter loads wait_states-1 on entry and decrements each cycle. When the counter is 0, go to RESP. Total time in WAIT is exactly wait_states cycles.
  - RESP: ack=1 for exactly one cycle, then return to IDLE. ready=0 in this state.
- Commit, on the edge that enters RESP:
  - Valid write: mem[index] <= latched data_out.
  - Valid read: data_in <= mem[index].
  - Errored access: no memory write, data_in <= 0, err <= 1.
  - Otherwise err <= 0.
- Output timing:
  - err and data_in are registered and hold their values until the next commit.
  - A write leaves data_in unchanged.
  - ack is high only in RESP.
- Latency: accept edge to ack high is wait_states+1 cycles.
- Back-to-back: earliest next accept is the IDLE cycle after RESP, so peak throughput is one access per wait_states+2 cycles.
- Read-after-write to the same word returns the new data, because the write is committed before ready returns.
- Address wrap: a data_addr below base_addr wraps to a large offset and is flagged out-of-range.

Test Plan:
1. Reset, then write 0x1234_5678 to base+0x10 and read base+0x10, with wait_states=1. Required: each ack arrives 2 cycles after accept, err=0, read data_in=0x1234_5678, write leaves data_in unchanged.
2. With wait_states=0, write 0xA5A5_0001 to base+0 and read base+0. Required: ack 1 cycle after accept, data_in=0xA5A5_0001. Hold req high continuously. Required: accepts occur every 2 cycles and ready=0 during RESP.
3. Write to base+0x6 (misaligned), then read base+4*depth_words (out of range), then read base-4 (wrap). Required: all three give ack with err=1 and data_in=0 on the reads. Reading base+0x4 afterwards shows it unmodified.
4. Pull reset low in the WAIT state of a write of 0xDEAD_BEEF to base+0x20, with wait_states=3. Required: ready=1, ack=0, err=0, data_in=0 immediately (asynchronous). After release, reading base+0x20 returns its prior value, not 0xDEAD_BEEF.
5. With wait_states=15, pulse req while in WAIT and RESP. Required: those pulses are ignored, exactly one ack occurs 16 cycles after accept, and no spurious second access happens.
6. Write the last word, base+4*(depth_words-1), with 0xFFFF_FFFF, and read it back. Required: err=0, data_in=0xFFFF_FFFF. Word 0 is unaffected.

Source files
------------

// File: rtl/mips_data_memory.sv
// mips_data_memory: word data memory responder for the MIPS data port with programmable wait states
module mips_data_memory #(
  parameter logic [31:0] base_addr   = 32'h0000_0000,
  parameter int          depth_words = 1024,
  parameter int          wait_states = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        data_rd_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        ready,
  output logic        ack,
  output logic        err
);
  localparam int          AW    = $clog2(depth_words);
  localparam logic [32:0] LIMIT = 33'(depth_words) * 33'd4;
  localparam logic [3:0]  WS_M1 = wait_states > 0 ? 4'(wait_states - 1) : 4'd0;
  localparam logic [1:0]  S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [31:0] mem [depth_words];
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, din_q, din_d;
  logic        rd_q, rd_d, err_q, err_d;
  logic [31:0] acc_addr, acc_wdata, offset;
  logic        acc_rd, bad, accept, commit, we;
  logic [AW-1:0] idx;
  // With zero wait states the commit edge is the accept edge, so the live inputs are used
  always_comb begin
    acc_addr  = state_q == S_IDLE ? data_addr : addr_q;
    acc_wdata = state_q == S_IDLE ? data_out : wdata_q;
    acc_rd    = state_q == S_IDLE ? data_rd_wr : rd_q;
    offset    = acc_addr - base_addr;
    bad       = (acc_addr[1:0] != 2'd0) || ({1'b0, offset} >= LIMIT);
    idx       = offset[AW+1:2];
    accept    = state_q == S_IDLE && req;
    commit    = (accept && wait_states == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    we        = commit && !acc_rd && !bad;
    state_d   = accept ? (wait_states == 0 ? S_RESP : S_WAIT)
              : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d     = accept ? WS_M1 : (state_q == S_WAIT && cnt_q != 4'd0) ? 4'(cnt_q - 4'd1) : 4'd0;
    addr_d    = accept ? data_addr : addr_q;
    wdata_d   = accept ? data_out : wdata_q;
    rd_d      = accept ? data_rd_wr : rd_q;
    err_d     = commit ? bad : err_q;
    din_d     = commit ? (bad ? 32'd0 : acc_rd ? mem[idx] : din_q) : din_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      din_q   <= din_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= acc_wdata;
  end
  assign data_in = din_q;
  assign err     = err_q;
  assign ready   = state_q == S_IDLE;
  assign ack     = state_q == S_RESP;
endmodule

// File: tb/tb_mips_data_memory.sv
// tb_mips_data_memory: scoreboard bench over four instances with 0, 1, 3 and 15 wait states
module tb_mips_data_memory;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] d;
    int          acc;
  } exp_t;
  logic        clk = 1'b0;
  int          cyc = 0;
  logic        rst [4];
  logic        req [4];
  logic        rd [4];
  logic [31:0] addr [4];
  logic [31:0] wd [4];
  logic [31:0] din [4];
  logic        rdy [4];
  logic        ack [4];
  logic        err [4];
  exp_t        sb [4][$];
  logic [31:0] mdl [4][DEPTH];
  bit          kn [4][DEPTH];
  logic [31:0] last_d [4];
  bit          last_k [4];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      mips_data_memory #(
        .base_addr(BASE), .depth_words(DEPTH),
        .wait_states(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 3 : 15)
      ) u_dut (
        .clk(clk), .reset(rst[g]), .req(req[g]), .data_rd_wr(rd[g]),
        .data_addr(addr[g]), .data_out(wd[g]), .data_in(din[g]),
        .ready(rdy[g]), .ack(ack[g]), .err(err[g])
      );
    end
  endgenerate
  function automatic int ws_of(int d);
    return d == 0 ? 0 : d == 1 ? 1 : d == 2 ? 3 : 15;
  endfunction
  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask
  function automatic exp_t predict(int d, bit rdw, logic [31:0] a, logic [31:0] w);
    exp_t e;
    logic [31:0] off = a - BASE;
    int i;
    e.err = (a % 4 != 0) || (off >= DEPTH * 4);
    e.acc = cyc;
    if (e.err) begin
      e.d = 0; e.chk = 1; last_d[d] = 0; last_k[d] = 1;
    end else begin
      i = int'(off / 4);
      if (rdw) begin
        e.d = mdl[d][i]; e.chk = kn[d][i]; last_d[d] = mdl[d][i]; last_k[d] = kn[d][i];
      end else begin
        e.d = last_d[d]; e.chk = last_k[d]; mdl[d][i] = w; kn[d][i] = 1;
      end
    end
    return e;
  endfunction
  task automatic wait_ready(int d);
    int n = 0;
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) chk("ready_timeout", d, {31'd0, rdy[d]}, 32'd1);
  endtask
  task automatic drive(int d, bit rdw, logic [31:0] a, logic [31:0] w);
    wait_ready(d);
    rd[d] = rdw; addr[d] = a; wd[d] = w; req[d] = 1'b1;
    sb[d].push_back(predict(d, rdw, a, w));
  endtask
  task automatic issue(int d, bit rdw, logic [31:0] a, logic [31:0] w);
    drive(d, rdw, a, w);
    @(negedge clk);
    req[d] = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (rst[d] && ack[d]) begin
        chk("ready_in_resp", d, {31'd0, rdy[d]}, 32'd0);
        if (sb[d].size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_ack dut%0d: got ack expected none", d);
        end else begin
          e = sb[d].pop_front();
          chk("latency", d, cyc - e.acc, ws_of(d) + 1);
          chk("err", d, {31'd0, err[d]}, {31'd0, e.err});
          if (e.chk) chk("data_in", d, din[d], e.d);
        end
      end
    end
  end
  initial begin
    int prev, n;
    logic [31:0] a;
    for (int d = 0; d < 4; d++) begin
      rst[d] = 0; req[d] = 0; rd[d] = 0; addr[d] = 0; wd[d] = 0; last_d[d] = 0; last_k[d] = 1;
    end
    #12;
    for (int d = 0; d < 4; d++) begin
      chk("rst_ready", d, {31'd0, rdy[d]}, 32'd1);
      chk("rst_ack", d, {31'd0, ack[d]}, 32'd0);
      chk("rst_err", d, {31'd0, err[d]}, 32'd0);
      chk("rst_din", d, din[d], 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) rst[d] = 1;
    @(negedge clk);
    // basic write then read with one wait state
    issue(1, 0, BASE + 32'h10, 32'h1234_5678);
    issue(1, 1, BASE + 32'h10, 32'h0);
    issue(1, 0, BASE + 32'h14, 32'h5555_AAAA);
    // zero wait states, req held high across back-to-back accesses
    issue(0, 0, BASE, 32'hA5A5_0001);
    issue(0, 1, BASE, 32'h0);
    wait_ready(0);
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready(0);
      if (k > 0) chk("b2b_spacing", 0, cyc - prev, 32'd2);
      prev = cyc;
      drive(0, k[0], BASE + 32'h8, 32'hC0DE_0000 + k);
      @(negedge clk);
    end
    req[0] = 0;
    // error accesses leave memory untouched
    issue(1, 0, BASE + 32'h4, 32'h0404_0404);
    issue(1, 0, BASE + 32'h6, 32'hBAD0_0006);
    issue(1, 1, BASE + 32'h4, 32'h0);
    issue(1, 1, BASE + 4 * DEPTH, 32'h0);
    issue(1, 1, BASE - 4, 32'h0);
    issue(1, 1, BASE + 32'h4, 32'h0);
    // reset during the WAIT of a write drops it
    issue(2, 0, BASE + 32'h20, 32'h0BAD_F00D);
    issue(2, 1, BASE + 32'h20, 32'h0);
    wait_ready(2);
    rd[2] = 0; addr[2] = BASE + 32'h20; wd[2] = 32'hDEAD_BEEF; req[2] = 1;
    @(negedge clk);
    req[2] = 0;
    chk("wait_not_ready", 2, {31'd0, rdy[2]}, 32'd0);
    @(negedge clk);
    #2 rst[2] = 0;
    #1;
    chk("async_rst_ready", 2, {31'd0, rdy[2]}, 32'd1);
    chk("async_rst_ack", 2, {31'd0, ack[2]}, 32'd0);
    chk("async_rst_err", 2, {31'd0, err[2]}, 32'd0);
    chk("async_rst_din", 2, din[2], 32'd0);
    last_d[2] = 0; last_k[2] = 1;
    @(negedge clk);
    rst[2] = 1;
    @(negedge clk);
    issue(2, 1, BASE + 32'h20, 32'h0);
    // requests pulsed during WAIT and RESP are ignored
    issue(3, 0, BASE + 32'h44, 32'h4444_0044);
    drive(3, 0, BASE + 32'h40, 32'h4040_0040);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req[3] = (k % 3 != 1); rd[3] = 0; addr[3] = BASE + 32'h44; wd[3] = $urandom;
    end
    @(negedge clk);
    req[3] = 0;
    issue(3, 1, BASE + 32'h44, 32'h0);
    issue(3, 1, BASE + 32'h40, 32'h0);
    // last word boundary
    issue(1, 0, BASE, 32'h0000_0BEE);
    issue(1, 0, BASE + 4 * (DEPTH - 1), 32'hFFFF_FFFF);
    issue(1, 1, BASE + 4 * (DEPTH - 1), 32'h0);
    issue(1, 1, BASE, 32'h0);
    issue(1, 1, BASE + 4 * DEPTH - 2, 32'h0);
    // randomized mix on every instance
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 25; k++) begin
        n = $urandom_range(0, 9);
        a = BASE + 4 * $urandom_range(0, 15);
        if (n == 0) a = a + $urandom_range(1, 3);
        else if (n == 1) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 7);
        else if (n == 2) a = BASE - 4 * $urandom_range(1, 4);
        issue(d, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < 4; d++) chk("pending_responses", d, sb[d].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
